mimo_narrow: RTL and testbench

- Wide-to-narrow gearbox. It is the disassembling counterpart of the team's narrow-to-wide MIMO accumulator.
- Accepts widthIn-bit words on a PipeIn-style enq handshake. Emits widthOut-bit slices, LSB first, on a PipeOut-style first/deq handshake.
- Sits between wide datapath producers, e.g. 128-bit memory or DMA beats, and narrow consumers, e.g. 32-bit stream or register paths.
- Internal bit buffer with an occupancy count; no bits are lost or reordered.

---
 rtl/mimo_narrow.sv | 108 ++++++++++
 tb/tb_mimo_narrow.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mimo_narrow.sv
// mimo_narrow: wide-to-narrow gearbox. It accepts widthIn-bit words on an
// enq handshake and emits widthOut-bit slices, LSB first, on a first/deq
// handshake. Optional flush (define MIMO_NARROW_FLUSH_EN) pads a short tail.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   in_enq__ENA/_v  producer enqueue request and data
//   in_enq__RDY     a whole word fits (occupancy <= widthOut)
//   out_deq__ENA    consumer dequeue request
//   out_deq__RDY    a full slice is buffered (occupancy >= widthOut)
//   out_first       head slice, buffer LSBs
//   out_first__RDY  same as out_deq__RDY
//   flush/__RDY     (MIMO_NARROW_FLUSH_EN only) zero-pad a partial tail
module mimo_narrow #(
  parameter int widthIn  = 128,
  parameter int widthOut = 32
) (
  input  logic                CLK,
  input  logic                RST,
`ifdef MIMO_NARROW_FLUSH_EN
  input  logic                flush,
  output logic                flush__RDY,
`endif
  input  logic                in_enq__ENA,
  input  logic [widthIn-1:0]  in_enq_v,
  output logic                in_enq__RDY,
  input  logic                out_deq__ENA,
  output logic                out_deq__RDY,
  output logic [widthOut-1:0] out_first,
  output logic                out_first__RDY
);

  localparam int BW = widthIn + widthOut;
  localparam int CW = $clog2(BW) + 1;

  localparam logic [CW-1:0] C_IN  = CW'(widthIn);
  localparam logic [CW-1:0] C_OUT = CW'(widthOut);

  logic [BW-1:0] r_buf;
  logic [CW-1:0] r_cnt;

  logic [BW-1:0] w_buf_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [BW-1:0] w_base;
  logic [CW-1:0] w_pos;
  logic [BW-1:0] w_ins;
  logic [BW-1:0] w_ins_mask;
  logic          w_enq_fire;
  logic          w_deq_fire;

  assign in_enq__RDY    = (r_cnt <= C_OUT);
  assign out_deq__RDY   = (r_cnt >= C_OUT);
  assign out_first__RDY = out_deq__RDY;
  assign out_first      = r_buf[widthOut-1:0];

  assign w_enq_fire = in_enq__ENA && in_enq__RDY;
  assign w_deq_fire = out_deq__ENA && out_deq__RDY;

  // On a simultaneous enq/deq the shift happens first, so the new word
  // lands at c-widthOut; both paths use one insertion point.
  assign w_base = w_deq_fire ? (r_buf >> widthOut) : r_buf;
  assign w_pos  = w_deq_fire ? (r_cnt - C_OUT) : r_cnt;

  assign w_ins      = BW'(in_enq_v) << w_pos;
  assign w_ins_mask = BW'({widthIn{1'b1}}) << w_pos;

`ifdef MIMO_NARROW_FLUSH_EN
  logic [BW-1:0] w_low_mask;
  logic          w_flush_fire;

  assign flush__RDY   = (r_cnt != '0) && (r_cnt < C_OUT);
  // enq wins; a flush that collides with it is dropped
  assign w_flush_fire = flush && flush__RDY && !w_enq_fire;
  assign w_low_mask   = ~({BW{1'b1}} << r_cnt);
`endif

  always_comb begin
    w_buf_nxt = w_base;
    w_cnt_nxt = r_cnt;
    if (w_enq_fire) begin
      w_buf_nxt = (w_base & ~w_ins_mask) | w_ins;
    end
    unique case ({w_enq_fire, w_deq_fire})
      2'b10:   w_cnt_nxt = r_cnt + C_IN;
      2'b01:   w_cnt_nxt = r_cnt - C_OUT;
      2'b11:   w_cnt_nxt = r_cnt + C_IN - C_OUT;
      default: w_cnt_nxt = r_cnt;
    endcase
`ifdef MIMO_NARROW_FLUSH_EN
    // clear the pad bits so the tail leaves as one zero-filled slice
    if (w_flush_fire) begin
      w_buf_nxt = r_buf & w_low_mask;
      w_cnt_nxt = C_OUT;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mimo_narrow.sv
// tb_mimo_narrow: directed table, hand sequences and random traffic
// against a bit-queue model for 128/32 and 48/32 gearboxes.
module tb_mimo_narrow;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic         a_enq, a_deq, a_erdy, a_drdy, a_frdy;
  logic [127:0] a_v;
  logic [31:0]  a_first;
  logic         b_enq, b_deq, b_erdy, b_drdy, b_frdy;
  logic [47:0]  b_v;
  logic [31:0]  b_first;
`ifdef MIMO_NARROW_FLUSH_EN
  logic a_fl, a_flrdy, b_fl, b_flrdy;
`endif

  mimo_narrow #(.widthIn(128), .widthOut(32)) u_a (
    .CLK(CLK), .RST(RST),
`ifdef MIMO_NARROW_FLUSH_EN
    .flush(a_fl), .flush__RDY(a_flrdy),
`endif
    .in_enq__ENA(a_enq), .in_enq_v(a_v), .in_enq__RDY(a_erdy),
    .out_deq__ENA(a_deq), .out_deq__RDY(a_drdy),
    .out_first(a_first), .out_first__RDY(a_frdy)
  );

  mimo_narrow #(.widthIn(48), .widthOut(32)) u_b (
    .CLK(CLK), .RST(RST),
`ifdef MIMO_NARROW_FLUSH_EN
    .flush(b_fl), .flush__RDY(b_flrdy),
`endif
    .in_enq__ENA(b_enq), .in_enq_v(b_v), .in_enq__RDY(b_erdy),
    .out_deq__ENA(b_deq), .out_deq__RDY(b_drdy),
    .out_first(b_first), .out_first__RDY(b_frdy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         enq;
    logic [127:0] d;
    logic         deq;
    logic [31:0]  f;
    logic         er;
    logic         dr;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(logic enq, logic [127:0] d, logic deq,
                              logic [31:0] f, logic er, logic dr);
    vec_t v;
    v.enq = enq; v.d = d; v.deq = deq;
    v.f = f; v.er = er; v.dr = dr;
    return v;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge CLK);
      chk($sformatf("tv%0d.first", i), 128'(a_first), 128'(tv[i].f));
      chk($sformatf("tv%0d.enq_rdy", i), 128'(a_erdy), 128'(tv[i].er));
      chk($sformatf("tv%0d.deq_rdy", i), 128'(a_drdy), 128'(tv[i].dr));
      chk($sformatf("tv%0d.first_rdy", i), 128'(a_frdy), 128'(tv[i].dr));
      a_enq = tv[i].enq;
      a_v   = tv[i].d;
      a_deq = tv[i].deq;
    end
    @(negedge CLK);
    a_enq = 1'b0;
    a_deq = 1'b0;
  endtask

  task automatic idle_all();
    a_enq = 1'b0; a_deq = 1'b0; a_v = '0;
    b_enq = 1'b0; b_deq = 1'b0; b_v = '0;
`ifdef MIMO_NARROW_FLUSH_EN
    a_fl = 1'b0; b_fl = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_all();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // behavioural model: plain FIFO of bits, LSB first
  bit qa[$];
  bit qb[$];

  function automatic logic [31:0] head(ref bit q[$]);
    logic [31:0] s;
    for (int j = 0; j < 32; j++) s[j] = q[j];
    return s;
  endfunction

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] WA = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] WB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] WJ = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0]  = mk(1, D1, 0, 32'h0,        1, 0);
    tv[1]  = mk(0, 0,  1, 32'h11111111, 0, 1);
    tv[2]  = mk(0, 0,  1, 32'h22222222, 0, 1);
    tv[3]  = mk(0, 0,  1, 32'h33333333, 0, 1);
    tv[4]  = mk(0, 0,  1, 32'h44444444, 1, 1);
    tv[5]  = mk(1, WA, 1, 32'h0,        1, 0);
    tv[6]  = mk(1, WB, 1, 32'hA0A0A0A0, 0, 1);
    tv[7]  = mk(1, WB, 1, 32'hA1A1A1A1, 0, 1);
    tv[8]  = mk(1, WJ, 1, 32'hA2A2A2A2, 0, 1);
    tv[9]  = mk(1, WB, 1, 32'hA3A3A3A3, 1, 1);
    tv[10] = mk(0, 0,  1, 32'hB0B0B0B0, 0, 1);
    tv[11] = mk(0, 0,  1, 32'hB1B1B1B1, 0, 1);
    tv[12] = mk(0, 0,  1, 32'hB2B2B2B2, 0, 1);
    tv[13] = mk(0, 0,  1, 32'hB3B3B3B3, 1, 1);
    tv[14] = mk(0, 0,  0, 32'h0,        1, 0);

    idle_all();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // single word drain, back-to-back with held deq, ignored enq
    run_rows(0, 14);

    // non-multiple widths: residual bits carry into next word
    @(negedge CLK);
    b_enq = 1'b1; b_v = 48'hBBBB_AAAA5555;
    @(negedge CLK);
    b_enq = 1'b0;
    chk("n48.s0", 128'(b_first), 128'(32'hAAAA5555));
    chk("n48.enq_rdy48", 128'(b_erdy), 128'(1'b0));
    b_deq = 1'b1;
    @(negedge CLK);
    b_deq = 1'b0;
    chk("n48.deq_rdy16", 128'(b_drdy), 128'(1'b0));
    chk("n48.enq_rdy16", 128'(b_erdy), 128'(1'b1));
    b_enq = 1'b1; b_v = 48'hDDDD_CCCC7777;
    @(negedge CLK);
    b_enq = 1'b0;
    chk("n48.s1", 128'(b_first), 128'(32'h7777BBBB));
    chk("n48.enq_rdy64", 128'(b_erdy), 128'(1'b0));
    b_deq = 1'b1;
    @(negedge CLK);
    chk("n48.s2", 128'(b_first), 128'(32'hDDDDCCCC));
    chk("n48.deq_rdy32", 128'(b_drdy), 128'(1'b1));
    @(negedge CLK);
    b_deq = 1'b0;
    chk("n48.empty", 128'(b_drdy), 128'(1'b0));

    // reset mid-stream, with a colliding enq that must lose
    @(negedge CLK);
    a_enq = 1'b1; a_v = D1;
    @(negedge CLK);
    a_enq = 1'b0; a_deq = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    a_deq = 1'b0;
    RST = 1'b1; a_enq = 1'b1; a_v = WA;
    @(negedge CLK);
    RST = 1'b0; a_enq = 1'b0;
    chk("rst.first", 128'(a_first), 128'(0));
    chk("rst.deq_rdy", 128'(a_drdy), 128'(1'b0));
    chk("rst.enq_rdy", 128'(a_erdy), 128'(1'b1));
    chk("rst.count", 128'(u_a.r_cnt), 128'(0));
    run_rows(0, 5);

`ifdef MIMO_NARROW_FLUSH_EN
    do_reset();
    @(negedge CLK);
    b_enq = 1'b1; b_v = 48'h0000_12345678;
    @(negedge CLK);
    b_enq = 1'b0; b_deq = 1'b1;
    @(negedge CLK);
    b_deq = 1'b0;
    chk("fl0.flush_rdy", 128'(b_flrdy), 128'(1'b1));
    b_fl = 1'b1;
    @(negedge CLK);
    b_fl = 1'b0;
    chk("fl0.first", 128'(b_first), 128'(0));
    chk("fl0.count", 128'(u_b.r_cnt), 128'(32));
    b_deq = 1'b1;
    @(negedge CLK);
    b_deq = 1'b0;
    chk("fl0.count_end", 128'(u_b.r_cnt), 128'(0));

    b_enq = 1'b1; b_v = 48'hABCD_12345678;
    @(negedge CLK);
    b_enq = 1'b0;
    chk("fl1.flush_rdy48", 128'(b_flrdy), 128'(1'b0));
    b_deq = 1'b1;
    @(negedge CLK);
    b_deq = 1'b0; b_fl = 1'b1;
    @(negedge CLK);
    b_fl = 1'b0;
    chk("fl1.first", 128'(b_first), 128'(32'h0000ABCD));
    chk("fl1.deq_rdy", 128'(b_drdy), 128'(1'b1));
    chk("fl1.flush_rdy", 128'(b_flrdy), 128'(1'b0));
    b_deq = 1'b1;
    @(negedge CLK);
    b_deq = 1'b0;
    chk("fl1.empty", 128'(b_drdy), 128'(1'b0));

    b_enq = 1'b1; b_v = 48'hABCD_12345678;
    @(negedge CLK);
    b_enq = 1'b0; b_deq = 1'b1;
    @(negedge CLK);
    b_deq = 1'b0; b_fl = 1'b1;
    b_enq = 1'b1; b_v = 48'h1111_22223333;
    @(negedge CLK);
    b_fl = 1'b0; b_enq = 1'b0;
    chk("fl2.first", 128'(b_first), 128'(32'h3333ABCD));
    chk("fl2.enq_rdy", 128'(b_erdy), 128'(1'b0));
    b_deq = 1'b1;
    @(negedge CLK);
    chk("fl2.s1", 128'(b_first), 128'(32'h11112222));
    @(negedge CLK);
    b_deq = 1'b0;
    chk("fl2.empty", 128'(b_drdy), 128'(1'b0));
`endif

    // random traffic on both instances against the bit-queue model
    do_reset();
    qa.delete();
    qb.delete();
    for (int n = 0; n < 800; n++) begin
      bit ea, da, eb, db;
      bit era, dra, erb, drb;
      logic [127:0] va;
      logic [47:0] vb;
      @(negedge CLK);
      era = (qa.size() <= 32);
      dra = (qa.size() >= 32);
      erb = (qb.size() <= 32);
      drb = (qb.size() >= 32);
      chk("rnd.a.enq_rdy", 128'(a_erdy), 128'(era));
      chk("rnd.a.deq_rdy", 128'(a_drdy), 128'(dra));
      chk("rnd.a.first_rdy", 128'(a_frdy), 128'(dra));
      chk("rnd.a.count", 128'(u_a.r_cnt), 128'(qa.size()));
      if (dra) chk("rnd.a.first", 128'(a_first), 128'(head(qa)));
      chk("rnd.b.enq_rdy", 128'(b_erdy), 128'(erb));
      chk("rnd.b.deq_rdy", 128'(b_drdy), 128'(drb));
      chk("rnd.b.count", 128'(u_b.r_cnt), 128'(qb.size()));
      if (drb) chk("rnd.b.first", 128'(b_first), 128'(head(qb)));
      if (qa.size() > 160 || qb.size() > 80) begin
        errors++;
        $display("FAIL rnd.bound: sizes %0d %0d", qa.size(), qb.size());
      end
      ea = 1'($urandom_range(0, 1));
      da = ($urandom_range(0, 3) != 0);
      eb = 1'($urandom_range(0, 1));
      db = ($urandom_range(0, 3) != 0);
      va = {$urandom, $urandom, $urandom, $urandom};
      vb = {16'($urandom), $urandom};
      a_enq = ea; a_deq = da; a_v = va;
      b_enq = eb; b_deq = db; b_v = vb;
      if (da && dra) repeat (32) void'(qa.pop_front());
      if (ea && era) for (int j = 0; j < 128; j++) qa.push_back(va[j]);
      if (db && drb) repeat (32) void'(qb.pop_front());
      if (eb && erb) for (int j = 0; j < 48; j++) qb.push_back(vb[j]);
    end
    @(negedge CLK);
    idle_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
